// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 pins static low, static high or from one shared 8-bit PWM waveform.
// Optional build macro PWM_SHADOW_EN: the duty cycle is shadowed and only reloaded at each period wrap.
module pwm_peripheral #(
  parameter int PRESCALE   = 3000,
  parameter int PRESCALE_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]            pwm_cnt_q, pwm_cnt_d;
  logic [15:0]           out_q, out_d;
  logic                  period_start_q, period_start_d;
  logic [15:0]           en_out, en_pwm;
  logic [7:0]            duty_act;
  logic                  tick, wrap, pwm_lvl;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign tick   = (presc_cnt_q == PRESC_MAX);
  assign wrap   = tick && (pwm_cnt_q == 8'hFF);

`ifdef PWM_SHADOW_EN
  // Duty only changes on the wrap clk, so a period is never cut short or stretched.
  logic [7:0] duty_act_q, duty_act_d;

  always_comb begin
    duty_act_d = duty_act_q;
    if (wrap) duty_act_d = pwm_duty_cycle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) duty_act_q <= 8'h00;
    else     duty_act_q <= duty_act_d;
  end

  assign duty_act = duty_act_q;
`else
  assign duty_act = pwm_duty_cycle;
`endif

  always_comb begin
    presc_cnt_d    = tick ? '0 : presc_cnt_q + PRESCALE_W'(1);
    pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    period_start_d = wrap;
    // Full-scale duty is forced high so there is no one-tick dropout at count 255.
    pwm_lvl        = (duty_act == 8'hFF) || (pwm_cnt_q < duty_act);
    out_d          = en_out & (~en_pwm | {16{pwm_lvl}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q    <= '0;
      pwm_cnt_q      <= 8'h00;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      presc_cnt_q    <= presc_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: self-checking bench for pwm_peripheral, with PRESCALE=4 and PRESCALE=1 instances side by side.
// The reference model derives counter state from the number of clocks since reset release.
module tb_pwm_peripheral;

  localparam int P0 = 4;
  localparam int P1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] enOut = 16'h0000;
  logic [15:0] enPwm = 16'h0000;
  logic [7:0]  duty = 8'h00;
  logic [15:0] out0, out1;
  logic        ps0, ps1;

  int errors = 0;
  int checks = 0;
  int kCnt [2];
`ifdef PWM_SHADOW_EN
  logic [7:0] shDuty [2];
`endif

  pwm_peripheral #(.PRESCALE(P0), .PRESCALE_W(12)) dut (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(enOut[7:0]), .en_reg_out_15_8(enOut[15:8]),
    .en_reg_pwm_7_0(enPwm[7:0]), .en_reg_pwm_15_8(enPwm[15:8]),
    .pwm_duty_cycle(duty), .out(out0), .period_start(ps0)
  );

  pwm_peripheral #(.PRESCALE(P1), .PRESCALE_W(4)) dut1 (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(enOut[7:0]), .en_reg_out_15_8(enOut[15:8]),
    .en_reg_pwm_7_0(enPwm[7:0]), .en_reg_pwm_15_8(enPwm[15:8]),
    .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
  );

  always #5 clk = ~clk;

  // Hard stop in case something downstream of a bounded loop still stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Clears the model's notion of elapsed time; the DUT restarts from count zero.
  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      kCnt[i] = 0;
`ifdef PWM_SHADOW_EN
      shDuty[i] = 8'h00;
`endif
    end
  endtask

  // One clock: predict both DUTs from the current inputs, advance, then compare.
  task automatic stepClk();
    logic [15:0] e [2];
    logic        p [2];
    logic [7:0]  d;
    int          cnt, pp;
    for (int i = 0; i < 2; i++) begin
      pp = (i == 0) ? P0 : P1;
`ifdef PWM_SHADOW_EN
      d = shDuty[i];
`else
      d = duty;
`endif
      cnt  = (kCnt[i] / pp) % 256;
      e[i] = ((d == 8'hFF) || (cnt < int'(d))) ? enOut : (enOut & ~enPwm);
      kCnt[i]++;
      p[i] = (kCnt[i] % (256 * pp)) == 0;
`ifdef PWM_SHADOW_EN
      if (p[i]) shDuty[i] = duty;
`endif
    end
    @(posedge clk);
    #1;
    checkOutput("out_p4", 32'(out0), 32'(e[0]));
    checkOutput("ps_p4", 32'(ps0), 32'(p[0]));
    checkOutput("out_p1", 32'(out1), 32'(e[1]));
    checkOutput("ps_p1", 32'(ps1), 32'(p[1]));
  endtask

  // Steps until the chosen instance shows period_start, giving up after 'bound' clocks.
  task automatic waitPs(input int which, input int bound, output int n);
    n = 0;
    do begin
      stepClk();
      n++;
    end while (((which == 0) ? ps0 : ps1) !== 1'b1 && n < bound);
    checkOutput("wait_ps_bound", 32'(((which == 0) ? ps0 : ps1) === 1'b1), 32'd1);
  endtask

  task automatic measureHigh(input int which, input int len, output int highs);
    highs = 0;
    for (int i = 0; i < len; i++) begin
      stepClk();
      if (((which == 0) ? out0[0] : out1[0]) === 1'b1) highs++;
    end
  endtask

  // Asserts reset between edges and checks the outputs clear without waiting for a clock.
  task automatic applyReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_async_out_p4", 32'(out0), 32'h0);
    checkOutput("rst_async_ps_p4", 32'(ps0), 32'h0);
    checkOutput("rst_async_out_p1", 32'(out1), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hold_out_p4", 32'(out0), 32'h0);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic applyStimulus(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] dc, input int cycles);
    enOut = eo;
    enPwm = ep;
    duty  = dc;
    for (int i = 0; i < cycles; i++) stepClk();
  endtask

  initial begin
    int n, highs;
    logic [7:0] sweep [5];
    int sweepExp [5];
    logic [7:0] dr;
    sweep    = '{8'h00, 8'h01, 8'h80, 8'hFE, 8'hFF};
    sweepExp = '{0, 4, 512, 1016, 1024};
    modelReset();

    // Power-on reset state, then release and time the first period start.
    #3;
    checkOutput("por_out", 32'(out0), 32'h0);
    checkOutput("por_ps", 32'(ps0), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitPs(0, 1100, n);
    checkOutput("first_ps_latency", 32'(n), 32'd1024);

    // Static mux: enabled non-PWM pins go high one clock later, then clear.
    enOut = 16'hA5A5; enPwm = 16'h0000; duty = 8'h80;
    stepClk();
    checkOutput("static_mux_on", 32'(out0), 32'hA5A5);
    enOut = 16'h0000;
    stepClk();
    checkOutput("static_mux_off", 32'(out0), 32'h0000);

    // Duty sweep on pin 0: high clocks per 1024-clock period.
    for (int s = 0; s < 5; s++) begin
      enOut = 16'h0001; enPwm = 16'h0001; duty = sweep[s];
      waitPs(0, 1100, n);
      measureHigh(0, 1024, highs);
      checkOutput($sformatf("duty_sweep_%0h", sweep[s]), 32'(highs), 32'(sweepExp[s]));
      checkOutput("sweep_period_end_ps", 32'(ps0), 32'd1);
    end

    // Single-clock prescale: duty 2 gives 2 high clocks per 256, period start every 256.
    duty = 8'h02;
    waitPs(1, 600, n);
    waitPs(1, 600, n);
    checkOutput("p1_ps_interval", 32'(n), 32'd256);
    measureHigh(1, 256, highs);
    checkOutput("p1_high_count", 32'(highs), 32'd2);
    checkOutput("p1_ps_after_256", 32'(ps1), 32'd1);

    // PWM select without output enable never drives a pin high.
    enOut = 16'h0000; enPwm = 16'hFFFF; duty = 8'hFF;
    highs = 0;
    for (int i = 0; i < 2048; i++) begin
      stepClk();
      if (out0 !== 16'h0000) highs++;
    end
    checkOutput("pwm_without_enable", 32'(highs), 32'd0);

    // Mid-period duty change 0x40 -> 0xC0 at count 0x60.
    enOut = 16'h0001; enPwm = 16'h0001; duty = 8'h40;
    waitPs(0, 1100, n);
    waitPs(0, 1100, n);
    highs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (i == 384) duty = 8'hC0;
      stepClk();
      if (out0[0] === 1'b1) highs++;
    end
`ifdef PWM_SHADOW_EN
    checkOutput("mid_change_cur_period", 32'(highs), 32'd256);
`else
    checkOutput("mid_change_cur_period", 32'(highs), 32'd640);
`endif
    measureHigh(0, 1024, highs);
    checkOutput("mid_change_next_period", 32'(highs), 32'd768);

    // Randomised segments with corner duties mixed in.
    for (int s = 0; s < 24; s++) begin
      case ($urandom_range(0, 5))
        0:       dr = 8'h00;
        1:       dr = 8'h01;
        2:       dr = 8'hFE;
        3:       dr = 8'hFF;
        default: dr = 8'($urandom);
      endcase
      applyStimulus(16'($urandom), 16'($urandom), dr, $urandom_range(1, 800));
    end

    // Reset mid-period with pins high, then re-time the first period start.
    applyStimulus(16'hFFFF, 16'h0000, 8'h33, 37);
    checkOutput("pins_high_before_rst", 32'(out0), 32'hFFFF);
    applyReset();
    waitPs(0, 1100, n);
    checkOutput("ps_latency_after_rst", 32'(n), 32'd1024);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
